// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared definitions for the OV5640 power-up / reset sequencer.
// Holds the sequencer state encoding and the default 50 MHz timing constants.
package ov5640_pkg;

    // Sequencer states; the encoding is visible on the seq_state port.
    typedef enum logic [2:0] {
        ST_PWUP  = 3'd0,
        ST_PDLOW = 3'd1,
        ST_RSTHI = 3'd2,
        ST_READY = 3'd3,
        ST_RUN   = 3'd4,
        ST_SLEEP = 3'd5,
        ST_WAKE  = 3'd6,
        ST_FAULT = 3'd7
    } seq_state_e;

    // Default delays in clk_50M cycles.
    localparam int T_PWUP_50M    = 262144;   // 5.24 ms PWDN high after reset
    localparam int T_RST_50M     = 65535;    // 1.31 ms PWDN low to RESETB high
    localparam int T_INIT_50M    = 1048575;  // 21 ms RESETB high to SCCB init
    localparam int T_WAKE_50M    = 65535;    // PWDN low (wake) to wake_done
    localparam int T_TIMEOUT_50M = 8388607;  // init_done watchdog
    localparam int MAX_RETRY_DEF = 3;        // re-power attempts before FAULT

endpackage

// File: rtl/ov5640_delay_cnt.sv
// ov5640_delay_cnt: shared up-counter for every timed sequencer state.
// Counts 0..target-1 while enabled; tc marks the last cycle of the delay.
module ov5640_delay_cnt #(
    parameter int CNT_W = 24
) (
    input  logic             clk_50M,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Count while enabled; the owner clears it on every state change.
    // NOTE: sequential state is written with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = en && (count == (target - 1'b1));

endmodule

// File: rtl/ov5640_power_seq.sv
// ov5640_power_seq: power-up / reset sequencer for NUM_CAM OV5640 sensors
// sharing one PWDN line, each with its own RESETB. Sequence: PWDN high,
// PWDN low, RESETB high, then initial_en to the SCCB configuration master.
// Also handles standby via PWDN, per-camera enable mask and software restart.
// Optional: define OV5640_INIT_TIMEOUT_EN to add an init_done watchdog with
// bounded re-power retries and a sticky fault; otherwise READY waits forever.
module ov5640_power_seq
    import ov5640_pkg::*;
#(
    parameter int NUM_CAM   = 2,
    parameter int CNT_W     = 24,
    parameter int T_PWUP    = T_PWUP_50M,
    parameter int T_RST     = T_RST_50M,
    parameter int T_INIT    = T_INIT_50M,
    parameter int T_WAKE    = T_WAKE_50M,
    parameter int T_TIMEOUT = T_TIMEOUT_50M,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic               clk_50M,
    input  logic               reset_n,
    input  logic [NUM_CAM-1:0] cam_en,
    input  logic               restart_req,
    input  logic               sleep_req,
    input  logic               init_done,
    output logic               camera_pwnd,
    output logic [NUM_CAM-1:0] camera_rstn,
    output logic               initial_en,
    output logic               wake_done,
    output logic [2:0]         seq_state,
    output logic               fault
);

    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    // Reject parameter sets the counter cannot represent.
    if (NUM_CAM < 1 || NUM_CAM > 8 || T_PWUP < 1 || T_RST < 1 || T_INIT < 1 ||
        T_WAKE < 1 || T_TIMEOUT < 1 || MAX_RETRY < 0 ||
        longint'(T_PWUP) >= CNT_RANGE || longint'(T_RST) >= CNT_RANGE ||
        longint'(T_INIT) >= CNT_RANGE || longint'(T_WAKE) >= CNT_RANGE ||
        longint'(T_TIMEOUT) >= CNT_RANGE) begin : g_param_err
        $error("ov5640_power_seq: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] TGT_PWUP = CNT_W'(T_PWUP);
    localparam logic [CNT_W-1:0] TGT_RST  = CNT_W'(T_RST);
    localparam logic [CNT_W-1:0] TGT_INIT = CNT_W'(T_INIT);
    localparam logic [CNT_W-1:0] TGT_WAKE = CNT_W'(T_WAKE);

    seq_state_e         state;
    seq_state_e         state_next;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic [CNT_W-1:0]   cnt_target;
    logic [NUM_CAM-1:0] cam_en_q;
    logic               pwnd_next;
    logic [NUM_CAM-1:0] rstn_next;
    logic               init_en_next;
    logic               wake_next;

`ifdef OV5640_INIT_TIMEOUT_EN
    localparam int                 RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]   TGT_TMO     = CNT_W'(T_TIMEOUT);

    logic [RETRY_W-1:0] retry;
    logic               retry_inc;
    logic               fault_set;
`endif

    ov5640_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .clk_50M (clk_50M),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .target  (cnt_target),
        .tc      (cnt_tc)
    );

    // Select the delay that applies to the current state.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_en     = 1'b0;
        cnt_target = '0;
        case (state)
            ST_PWUP:  begin cnt_en = 1'b1; cnt_target = TGT_PWUP; end
            ST_PDLOW: begin cnt_en = 1'b1; cnt_target = TGT_RST;  end
            ST_RSTHI: begin cnt_en = 1'b1; cnt_target = TGT_INIT; end
            ST_WAKE:  begin cnt_en = 1'b1; cnt_target = TGT_WAKE; end
`ifdef OV5640_INIT_TIMEOUT_EN
            ST_READY: begin cnt_en = 1'b1; cnt_target = TGT_TMO;  end
`endif
            default:  ;
        endcase
    end

    // Every timed state starts from zero, including a restart that stays in PWUP.
    assign cnt_clr = restart_req || (state_next != state);

    // Next-state logic; restart_req overrides every other transition.
    always_comb begin
        state_next = state;
`ifdef OV5640_INIT_TIMEOUT_EN
        retry_inc  = 1'b0;
        fault_set  = 1'b0;
`endif
        if (restart_req) begin
            state_next = ST_PWUP;
        end else begin
            case (state)
                ST_PWUP:  if (cnt_tc) state_next = ST_PDLOW;
                ST_PDLOW: if (cnt_tc) state_next = ST_RSTHI;
                ST_RSTHI: if (cnt_tc) state_next = ST_READY;
                ST_READY: begin
                    if (init_done) begin
                        state_next = ST_RUN;
                    end
`ifdef OV5640_INIT_TIMEOUT_EN
                    else if (cnt_tc) begin
                        if (retry < RETRY_LIMIT) begin
                            retry_inc  = 1'b1;
                            state_next = ST_PWUP;
                        end else begin
                            fault_set  = 1'b1;
                            state_next = ST_FAULT;
                        end
                    end
`endif
                end
                ST_RUN:   if (sleep_req)  state_next = ST_SLEEP;
                ST_SLEEP: if (!sleep_req) state_next = ST_WAKE;
                ST_WAKE:  if (cnt_tc)     state_next = ST_RUN;
                ST_FAULT: state_next = ST_FAULT;
                default:  state_next = ST_PWUP;
            endcase
        end
    end

    // Decode the pin levels for the state being entered, so registered
    // outputs change on the first cycle of that state.
    always_comb begin
        pwnd_next    = 1'b1;
        rstn_next    = '0;
        init_en_next = 1'b0;
        case (state_next)
            ST_PDLOW: pwnd_next = 1'b0;
            ST_RSTHI: begin pwnd_next = 1'b0; rstn_next = cam_en_q; end
            ST_READY,
            ST_RUN:   begin pwnd_next = 1'b0; rstn_next = cam_en_q; init_en_next = 1'b1; end
            ST_SLEEP: rstn_next = cam_en_q;
            ST_WAKE:  begin pwnd_next = 1'b0; rstn_next = cam_en_q; end
            default:  ;
        endcase
        wake_next = (state == ST_WAKE) && (state_next == ST_RUN);
    end

    // State and registered sensor-facing outputs.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PWUP;
            camera_pwnd <= 1'b1;
            camera_rstn <= '0;
            initial_en  <= 1'b0;
            wake_done   <= 1'b0;
        end else begin
            state       <= state_next;
            camera_pwnd <= pwnd_next;
            camera_rstn <= rstn_next;
            initial_en  <= init_en_next;
            wake_done   <= wake_next;
        end
    end

    // The enable mask follows cam_en during power-up and is frozen afterwards.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            cam_en_q <= '0;
        end else if (restart_req || state == ST_PWUP) begin
            cam_en_q <= cam_en;
        end
    end

    assign seq_state = state;

`ifdef OV5640_INIT_TIMEOUT_EN
    // Retry count and sticky fault; only a restart out of FAULT clears them both.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            retry <= '0;
            fault <= 1'b0;
        end else if (restart_req && state == ST_FAULT) begin
            retry <= '0;
            fault <= 1'b0;
        end else begin
            if (state_next == ST_RUN && state != ST_RUN) begin
                retry <= '0;
            end else if (retry_inc) begin
                retry <= retry + 1'b1;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_power_seq.sv
// tb_ov5640_power_seq: randomized scoreboard bench for ov5640_power_seq.
// A phase/elapsed-time reference model predicts the outputs after every
// clock edge; a separate monitor pops and compares on the falling edge.
module tb_ov5640_power_seq;

    localparam int NUM_CAM   = 2;
    localparam int CNT_W     = 8;
    localparam int T_PWUP    = 8;
    localparam int T_RST     = 4;
    localparam int T_INIT    = 6;
    localparam int T_WAKE    = 3;
    localparam int T_TIMEOUT = 10;
    localparam int MAX_RETRY = 2;

    typedef enum int {
        P_PWUP = 0, P_PDLOW = 1, P_RSTHI = 2, P_READY = 3,
        P_RUN  = 4, P_SLEEP = 5, P_WAKE  = 6, P_FAULT = 7
    } phase_e;

    typedef struct packed {
        logic               pwnd;
        logic [NUM_CAM-1:0] rstn;
        logic               init_en;
        logic               wake;
        logic [2:0]         st;
        logic               fault;
    } out_t;

    logic               clk_50M = 1'b0;
    logic               reset_n;
    logic [NUM_CAM-1:0] cam_en;
    logic               restart_req;
    logic               sleep_req;
    logic               init_done;
    logic               camera_pwnd;
    logic [NUM_CAM-1:0] camera_rstn;
    logic               initial_en;
    logic               wake_done;
    logic [2:0]         seq_state;
    logic               fault;

    ov5640_power_seq #(
        .NUM_CAM   (NUM_CAM),
        .CNT_W     (CNT_W),
        .T_PWUP    (T_PWUP),
        .T_RST     (T_RST),
        .T_INIT    (T_INIT),
        .T_WAKE    (T_WAKE),
        .T_TIMEOUT (T_TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk_50M     (clk_50M),
        .reset_n     (reset_n),
        .cam_en      (cam_en),
        .restart_req (restart_req),
        .sleep_req   (sleep_req),
        .init_done   (init_done),
        .camera_pwnd (camera_pwnd),
        .camera_rstn (camera_rstn),
        .initial_en  (initial_en),
        .wake_done   (wake_done),
        .seq_state   (seq_state),
        .fault       (fault)
    );

    always #10 clk_50M = ~clk_50M;

    int   checks = 0;
    int   errors = 0;
    out_t sb_q[$];

    // Reference model: current phase, cycles spent in it, frozen mask, retries.
    phase_e             m_ph;
    int                 m_el;
    logic [NUM_CAM-1:0] m_mask;
    int                 m_retry;
    bit                 m_fault;
    bit                 m_wake;

    logic [NUM_CAM-1:0] cur_en;
    logic               cur_sleep;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o = {camera_pwnd, camera_rstn, initial_en, wake_done, seq_state, fault};
        return o;
    endfunction

    function automatic out_t model_out();
        out_t o;
        o.pwnd    = (m_ph == P_PWUP) || (m_ph == P_SLEEP) || (m_ph == P_FAULT);
        o.rstn    = (m_ph inside {P_RSTHI, P_READY, P_RUN, P_SLEEP, P_WAKE}) ? m_mask : '0;
        o.init_en = (m_ph == P_READY) || (m_ph == P_RUN);
        o.wake    = m_wake;
        o.st      = 3'(m_ph);
        o.fault   = m_fault;
        return o;
    endfunction

    task automatic model_reset();
        m_ph    = P_PWUP;
        m_el    = 0;
        m_mask  = cam_en;
        m_retry = 0;
        m_fault = 1'b0;
        m_wake  = 1'b0;
    endtask

    task automatic go(input phase_e p);
        m_ph = p;
        m_el = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        m_wake = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (restart_req) begin
            if (m_ph == P_FAULT) begin
                m_fault = 1'b0;
                m_retry = 0;
            end
            go(P_PWUP);
            m_mask = cam_en;
        end else begin
            if (m_ph == P_PWUP) m_mask = cam_en;
            m_el++;
            case (m_ph)
                P_PWUP:  if (m_el == T_PWUP) go(P_PDLOW);
                P_PDLOW: if (m_el == T_RST)  go(P_RSTHI);
                P_RSTHI: if (m_el == T_INIT) go(P_READY);
                P_READY: begin
                    if (init_done) begin
                        go(P_RUN);
                        m_retry = 0;
                    end
`ifdef OV5640_INIT_TIMEOUT_EN
                    else if (m_el == T_TIMEOUT) begin
                        if (m_retry < MAX_RETRY) begin
                            m_retry++;
                            go(P_PWUP);
                        end else begin
                            m_fault = 1'b1;
                            go(P_FAULT);
                        end
                    end
`endif
                end
                P_RUN:   if (sleep_req)  go(P_SLEEP);
                P_SLEEP: if (!sleep_req) go(P_WAKE);
                P_WAKE: begin
                    if (m_el == T_WAKE) begin
                        go(P_RUN);
                        m_wake = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of stimulus, then record the predicted post-edge outputs.
    task automatic cycle(input logic rst, input logic [NUM_CAM-1:0] en,
                         input logic rs, input logic sl, input logic id);
        reset_n     = rst;
        cam_en      = en;
        restart_req = rs;
        sleep_req   = sl;
        init_done   = id;
        @(posedge clk_50M);
        model_step();
        sb_q.push_back(model_out());
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, cur_en, 1'b0, cur_sleep, 1'b0);
    endtask

    task automatic restart();
        cycle(1'b1, cur_en, 1'b1, cur_sleep, 1'b0);
    endtask

    task automatic run_until(input phase_e target, input int budget);
        int n;
        n = 0;
        while (m_ph != target && n < budget) begin
            idle(1);
            n++;
        end
        if (m_ph != target) begin
            checks++;
            errors++;
            $display("FAIL run_until: phase %0d not reached in %0d cycles", target, budget);
        end
    endtask

    // Assert reset_n away from any clock edge and expect immediate reset values.
    task automatic async_reset();
        @(negedge clk_50M);
        #3;
        cam_en  = cur_en;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_out(), model_out());
        cycle(1'b0, cur_en, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every recorded expectation on the following falling edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk_50M);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("outputs", dut_out(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rs;
        logic id;
        reset_n     = 1'b0;
        cam_en      = 2'b11;
        restart_req = 1'b0;
        sleep_req   = 1'b0;
        init_done   = 1'b0;
        cur_en      = 2'b11;
        cur_sleep   = 1'b0;
        model_reset();
        repeat (3) cycle(1'b0, cur_en, 1'b0, 1'b0, 1'b0);

        // Power-up with both cameras, then configuration done.
        run_until(P_READY, 40);
        idle(3);
        cycle(1'b1, cur_en, 1'b0, 1'b0, 1'b1);

        // Standby and wake; init_done in RUN is ignored.
        cycle(1'b1, cur_en, 1'b0, 1'b0, 1'b1);
        cur_sleep = 1'b1;
        idle(4);
        cur_sleep = 1'b0;
        idle(6);

        // Restart in the middle of RSTHI, then a clean re-sequence.
        restart();
        run_until(P_RSTHI, 40);
        idle(2);
        restart();
        run_until(P_READY, 40);

        // sleep_req together with init_done in READY: RUN first, then SLEEP.
        cycle(1'b1, cur_en, 1'b0, 1'b1, 1'b1);
        cur_sleep = 1'b1;
        idle(2);
        cur_sleep = 1'b0;
        idle(5);

        // Camera mask 01; later cam_en changes must not reach camera_rstn.
        cur_en = 2'b01;
        async_reset();
        run_until(P_READY, 40);
        cycle(1'b1, cur_en, 1'b0, 1'b0, 1'b1);
        cur_en = 2'b10;
        idle(3);
        cur_sleep = 1'b1;
        idle(2);
        cur_sleep = 1'b0;
        idle(5);

        // Asynchronous reset in the middle of PDLOW.
        cur_en = 2'b11;
        restart();
        run_until(P_PDLOW, 40);
        idle(1);
        async_reset();
        cycle(1'b0, cur_en, 1'b0, 1'b0, 1'b0);
        run_until(P_READY, 40);
        cycle(1'b1, cur_en, 1'b0, 1'b0, 1'b1);

`ifdef OV5640_INIT_TIMEOUT_EN
        // Withhold init_done: two re-powers, then FAULT; restart clears it.
        restart();
        run_until(P_FAULT, 200);
        idle(4);
        restart();
        run_until(P_READY, 40);
        cycle(1'b1, cur_en, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 49) == 0);
            id = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) cur_sleep = ~cur_sleep;
            if (!rs && (m_ph inside {P_PDLOW, P_RSTHI, P_RUN, P_SLEEP, P_WAKE}) &&
                $urandom_range(0, 7) == 0) begin
                cur_en = NUM_CAM'($urandom);
            end
            cycle(1'b1, cur_en, rs, cur_sleep, id);
        end

        idle(2);
        @(negedge clk_50M);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
